// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: PC redirect/stall controls from decode, the combinational ROM port,
// and the registered fetch outputs.
interface instr_fetch_unit_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  stall;
   logic                  redirect_valid;
   logic [DATA_WIDTH-1:0] redirect_addr;
   logic [DATA_WIDTH-1:0] rom_addr;
   logic [DATA_WIDTH-1:0] rom_q;
   logic                  if_valid;
   logic [DATA_WIDTH-1:0] if_instr;
   logic [DATA_WIDTH-1:0] if_pc;
   logic [DATA_WIDTH-1:0] if_pc_plus4;
   logic                  fetch_fault;

   modport master (
      input  stall, redirect_valid, redirect_addr, rom_q,
      output rom_addr, if_valid, if_instr, if_pc, if_pc_plus4, fetch_fault
   );

   modport slave (
      output stall, redirect_valid, redirect_addr, rom_q,
      input  rom_addr, if_valid, if_instr, if_pc, if_pc_plus4, fetch_fault
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC/fetch stage with ROM-window fault detection and halt.
// Optional saturating fetch/bubble counters when FETCH_PERF_CNT_EN is defined.
module instr_fetch_unit #(
   parameter int unsigned          DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC  = 32'h00400000,
   parameter int unsigned          ROM_DEPTH  = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]          fetch_count,
   output logic [31:0]          bubble_count,
`endif
   instr_fetch_unit_if.master   bus
);

   typedef enum logic {RUN, HALT} state_t;

   // Window bounds are one bit wider so RESET_PC + 4*ROM_DEPTH cannot wrap.
   localparam logic [DATA_WIDTH:0] WIN_LO = {1'b0, RESET_PC};
   localparam logic [DATA_WIDTH:0] WIN_HI = WIN_LO + ((DATA_WIDTH+1)'(ROM_DEPTH) << 2);

   state_t                state;
   logic [DATA_WIDTH-1:0] pc;
   logic                  if_valid;
   logic [DATA_WIDTH-1:0] if_instr;
   logic [DATA_WIDTH-1:0] if_pc;
   logic                  fetch_fault;

   logic [DATA_WIDTH:0]   pc_ext;
   logic                  pc_ok;
   logic                  do_fetch;
   logic                  do_bubble;

   always_comb begin
      pc_ext    = {1'b0, pc};
      pc_ok     = (pc[1:0] == 2'b00) && (pc_ext >= WIN_LO) && (pc_ext < WIN_HI);
      do_fetch  = (state == RUN) && !bus.redirect_valid && !bus.stall && pc_ok;
      do_bubble = (state == RUN) && (bus.redirect_valid || bus.stall);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= RUN;
         pc          <= RESET_PC;
         if_valid    <= 1'b0;
         if_instr    <= '0;
         if_pc       <= RESET_PC;
         fetch_fault <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (bus.redirect_valid) begin
                  pc       <= bus.redirect_addr;
                  if_valid <= 1'b0;
               end else if (bus.stall) begin
                  pc       <= pc;
               end else if (!pc_ok) begin
                  state       <= HALT;
                  fetch_fault <= 1'b1;
                  if_valid    <= 1'b0;
                  if_pc       <= pc;
               end else begin
                  if_instr <= bus.rom_q;
                  if_pc    <= pc;
                  if_valid <= 1'b1;
                  pc       <= pc + DATA_WIDTH'(4);
               end
            end
            HALT: begin
               if_valid    <= 1'b0;
               fetch_fault <= 1'b1;
            end
            default: begin
               state       <= HALT;
               if_valid    <= 1'b0;
               fetch_fault <= 1'b1;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_count  <= '0;
         bubble_count <= '0;
      end else begin
         if (do_fetch && (fetch_count != '1))
            fetch_count <= fetch_count + 32'd1;
         if (do_bubble && (bubble_count != '1))
            bubble_count <= bubble_count + 32'd1;
      end
   end
`endif

   assign bus.rom_addr    = pc;
   assign bus.if_valid    = if_valid;
   assign bus.if_instr    = if_instr;
   assign bus.if_pc       = if_pc;
   assign bus.if_pc_plus4 = if_pc + DATA_WIDTH'(4);
   assign bus.fetch_fault = fetch_fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random stall/redirect traffic
// checked against a behavioural fetch model (counters checked when FETCH_PERF_CNT_EN is defined).
module tb_instr_fetch_unit;

   localparam logic [31:0] BASE  = 32'h00400000;
   localparam int unsigned DEPTH = 64;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   instr_fetch_unit_if #(.DATA_WIDTH(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count;
   logic [31:0] bubble_count;
`endif

   instr_fetch_unit #(
      .DATA_WIDTH(32),
      .RESET_PC  (BASE),
      .ROM_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
`ifdef FETCH_PERF_CNT_EN
      .fetch_count (fetch_count),
      .bubble_count(bubble_count),
`endif
      .bus         (bus)
   );

   logic [31:0] rom [DEPTH];

   function automatic bit addr_ok(input logic [31:0] a);
      longint unsigned x;
      x = longint'(a);
      return (x % 4 == 0) && (x >= longint'(BASE)) && (x < longint'(BASE) + 4 * DEPTH);
   endfunction

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      if (addr_ok(a)) return rom[(a - BASE) / 4];
      return 32'hDEADBEEF;
   endfunction

   always_comb bus.rom_q = rom_word(bus.rom_addr);

   // Reference model: architectural view of the fetch stage.
   logic [31:0] m_pc, m_instr, m_ifpc, m_fcnt, m_bcnt;
   bit          m_valid, m_fault, m_halted;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit s, input bit v, input logic [31:0] a);
      if (!r) begin
         m_pc = BASE; m_valid = 0; m_instr = 0; m_ifpc = BASE; m_fault = 0; m_halted = 0;
         m_fcnt = 0; m_bcnt = 0;
      end else if (m_halted) begin
         m_valid = 0;
      end else if (v || s) begin
         if (m_bcnt != 32'hFFFFFFFF) m_bcnt++;
         if (v) begin
            m_pc = a;
            m_valid = 0;
         end
      end else if (!addr_ok(m_pc)) begin
         m_halted = 1; m_fault = 1; m_valid = 0; m_ifpc = m_pc;
      end else begin
         m_instr = rom_word(m_pc);
         m_ifpc  = m_pc;
         m_valid = 1;
         m_pc    = m_pc + 4;
         if (m_fcnt != 32'hFFFFFFFF) m_fcnt++;
      end
   endtask

   task automatic check_all();
      check("rom_addr",    bus.rom_addr,           m_pc);
      check("if_valid",    32'(bus.if_valid),      32'(m_valid));
      check("if_instr",    bus.if_instr,           m_instr);
      check("if_pc",       bus.if_pc,              m_ifpc);
      check("if_pc_plus4", bus.if_pc_plus4,        m_ifpc + 4);
      check("fetch_fault", 32'(bus.fetch_fault),   32'(m_fault));
`ifdef FETCH_PERF_CNT_EN
      check("fetch_count",  fetch_count,  m_fcnt);
      check("bubble_count", bubble_count, m_bcnt);
`endif
   endtask

   task automatic cycle(input bit r, input bit s, input bit v, input logic [31:0] a);
      rst_n              = r;
      bus.stall          = s;
      bus.redirect_valid = v;
      bus.redirect_addr  = a;
      model_step(r, s, v, a);
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      for (int i = 0; i < int'(DEPTH); i++) rom[i] = $urandom;
      rom[0] = 32'h20080005;
      rom[1] = 32'h20090003;
      rst_n = 1'b0; bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_addr = '0;

      // Reset values
      cycle(0, 0, 0, 0);
      cycle(0, 1, 1, 32'h00400040);
      check("rst_valid", 32'(bus.if_valid), 0);
      check("rst_pc",    bus.if_pc,    BASE);
      check("rst_instr", bus.if_instr, 0);
      check("rst_fault", 32'(bus.fetch_fault), 0);

      // First fetches after release
      cycle(1, 0, 0, 0);
      check("f1_valid", 32'(bus.if_valid), 1);
      check("f1_pc",    bus.if_pc,    32'h00400000);
      check("f1_instr", bus.if_instr, 32'h20080005);
      cycle(1, 0, 0, 0);
      check("f2_pc",    bus.if_pc,       32'h00400004);
      check("f2_plus4", bus.if_pc_plus4, 32'h00400008);
      cycle(1, 0, 0, 0);

      // Stall holds everything
      for (int i = 0; i < 3; i++) begin
         cycle(1, 1, 0, 0);
         check("stall_pc",   bus.if_pc,    32'h00400008);
         check("stall_rom",  bus.rom_addr, 32'h0040000C);
         check("stall_instr", bus.if_instr, rom[2]);
      end
      cycle(1, 0, 0, 0);
      check("resume_pc", bus.if_pc, 32'h0040000C);

      // Redirect wins over stall
      cycle(1, 1, 1, 32'h00400020);
      check("redir_bubble", 32'(bus.if_valid), 0);
      check("redir_rom",    bus.rom_addr, 32'h00400020);
      cycle(1, 0, 0, 0);
      check("redir_pc",    bus.if_pc, 32'h00400020);
      check("redir_valid", 32'(bus.if_valid), 1);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         bit          rr, ss, vv;
         logic [31:0] aa;
         rr = ($urandom_range(0, 99) >= 2);
         ss = ($urandom_range(0, 3) == 0);
         vv = ($urandom_range(0, 9) == 0);
         aa = BASE + 4 * $urandom_range(0, DEPTH - 1);
         if ($urandom_range(0, 19) == 0) aa = aa + 2;
         cycle(rr, ss, vv, aa);
      end

      // Misaligned redirect -> bubble then halt
      cycle(0, 0, 0, 0);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 1, 32'h00400002);
      check("mis_bubble", 32'(bus.if_valid), 0);
      cycle(1, 0, 0, 0);
      check("mis_fault", 32'(bus.fetch_fault), 1);
      check("mis_pc",    bus.if_pc, 32'h00400002);
      cycle(1, 0, 1, 32'h00400010);
      cycle(1, 1, 0, 0);
      check("halt_rom",   bus.rom_addr, 32'h00400002);
      check("halt_fault", 32'(bus.fetch_fault), 1);
      cycle(0, 1, 1, 32'h00400010);
      check("halt_rst", 32'(bus.fetch_fault), 0);

      // Sequential run to the top of the window
      for (int i = 0; i < int'(DEPTH); i++) cycle(1, 0, 0, 0);
      check("top_last_pc",    bus.if_pc, 32'h004000FC);
      check("top_last_valid", 32'(bus.if_valid), 1);
      cycle(1, 0, 0, 0);
      check("top_fault",    32'(bus.fetch_fault), 1);
      check("top_fault_pc", bus.if_pc, 32'h00400100);

`ifdef FETCH_PERF_CNT_EN
      cycle(0, 0, 0, 0);
      for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0);
      cycle(1, 1, 0, 0);
      cycle(1, 1, 0, 0);
      cycle(1, 0, 1, BASE);
      check("perf_fetch",  fetch_count,  10);
      check("perf_bubble", bubble_count, 3);
      cycle(0, 0, 0, 0);
      check("perf_rst_fetch",  fetch_count,  0);
      check("perf_rst_bubble", bubble_count, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Program-counter and fetch stage that drives the address of the combinational instruction ROM and registers the returned word for decode. It holds the PC, which starts at the text-segment base, steps it by 4, and accepts branch/jump redirects from downstream. It also takes stall requests. It checks every fetch address against the ROM window and halts on an illegal fetch.

Parameters:
- DATA_WIDTH, 32, width of PC, ROM address and instruction word.
- RESET_PC, 32'h00400000, PC after reset; base of the ROM window.
- ROM_DEPTH, 64, number of 32-bit words in the instruction ROM.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- rst_n, input, 1, synchronous reset, active-low, sampled on rising clk.
- stall, input, 1, decode cannot accept; hold PC and fetch register.
- redirect_valid, input, 1, branch/jump taken this cycle.
- redirect_addr, input, DATA_WIDTH, new PC target.
- rom_addr, output, DATA_WIDTH, byte address to the instruction ROM (= pc, combinational).
- rom_q, input, DATA_WIDTH, instruction word returned combinationally by the ROM.
- if_valid, output, 1, if_instr/if_pc hold a valid fetched instruction.
- if_instr, output, DATA_WIDTH, registered instruction.
- if_pc, output, DATA_WIDTH, PC of if_instr.
- if_pc_plus4, output, DATA_WIDTH, if_pc + 4 (combinational from if_pc).
- fetch_fault, output, 1, sticky illegal-fetch flag.

Behaviour:
- Reset (rst_n=0 at edge): pc=RESET_PC, state=RUN, if_valid=0, if_instr=0, if_pc=RESET_PC, fetch_fault=0. Reset overrides every other input.
- pc_ok is true when both hold:
  - pc[1:0]==0
  - RESET_PC <= pc < RESET_PC+4*ROM_DEPTH, compared unsigned at DATA_WIDTH+1 bits so the upper bound cannot overflow.
- The FSM has two states, RUN and HALT. Priority per edge in RUN is redirect > stall > fault check > normal fetch:
  - redirect_valid=1, with or without stall: pc<=redirect_addr, if_valid<=0 (one-cycle bubble), if_instr and if_pc held.
  - stall=1, no redirect: pc, if_valid, if_instr and if_pc are all held.
  - !pc_ok: state<=HALT, fetch_fault<=1, if_valid<=0, if_pc<=pc (records the faulting address).
  - Otherwise: if_instr<=rom_q, if_pc<=pc, if_valid<=1, pc<=pc+4 (mod 2^DATA_WIDTH).
- Latency: the instruction at address A appears on if_instr one edge after pc==A is fetched. After reset is released, the first valid instruction is presented one cycle later.
- A misaligned or out-of-window redirect_addr is not checked when it is accepted. It faults on the following fetch attempt.
- PC wrap at the top of the window (pc+4 == RESET_PC+4*ROM_DEPTH) is caught as a fault on the next fetch, never silently wrapped.
- HALT ignores stall and redirect and keeps pc frozen. if_valid=0 and fetch_fault=1 until reset.
- Reset asserted mid-stall or mid-redirect returns to the reset values on that edge.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds output fetch_count [31:0] and output bubble_count [31:0], both reset to 0 on rst_n=0.
  - fetch_count increments on each edge performing a normal fetch.
  - bubble_count increments on each edge in RUN where redirect_valid=1 or stall=1.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: neither port nor counter logic exists. All other behaviour is identical.

Test Plan:
- Reset release, no stall, ROM words 0x20080005 and 0x20090003 at 0x400000 and 0x400004 -> cycle 1: if_valid=1, if_pc=0x400000, if_instr=0x20080005; cycle 2: if_pc=0x400004, if_pc_plus4=0x400008.
- stall=1 for 3 cycles while if_pc=0x400008 -> if_pc, if_instr and if_valid unchanged; rom_addr stays 0x40000C; fetch resumes at 0x40000C when stall drops.
- redirect_valid=1, redirect_addr=0x400020, with stall=1 in the same cycle -> next cycle if_valid=0 and rom_addr=0x400020; following cycle if_pc=0x400020 with if_valid=1.
- redirect_addr=0x400002 -> one bubble cycle, then fetch_fault=1, state HALT, if_pc=0x400002, if_valid=0; later redirects are ignored until rst_n=0 clears fetch_fault.
- Sequential run from 0x400000 with ROM_DEPTH=64 -> last valid if_pc=0x4000FC; the next edge sets fetch_fault=1 with if_pc=0x400100.
- With FETCH_PERF_CNT_EN defined: 10 fetches, 2 stall cycles, 1 redirect -> fetch_count=10, bubble_count=3; rst_n=0 clears both to 0.
